// File: rtl/linebuf_window_sequencer_if.sv
// Pixel stream bundle between the window sequencer and its source/sink.
// Handshake: an input pixel transfers in any cycle where in_valid and in_ready are both high;
// out_valid is a one-cycle pulse that the sink must take, with space guaranteed by out_ready at the beat.
interface linebuf_window_sequencer_if #(
  parameter int CW = 11,
  parameter int RW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          border;
  logic          frame_done;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, out_col, out_row, border, frame_done
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, out_col, out_row, border, frame_done
  );
endinterface

// File: rtl/linebuf_window_sequencer.sv
// Frame sequencer for the WIN-1 row-delay FIFO cascade: drives clken/enable, appends
// flush beats, and reports window-centre coordinates aligned with the cascade output.
module linebuf_window_sequencer #(
  parameter int WIN = 3,
  parameter int CW  = 11,
  parameter int RW  = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CW-1:0]                 width,
  input  logic [RW-1:0]                 height,
  linebuf_window_sequencer_if.master    s,
  output logic                          fifo_clken,
  output logic                          fifo_enable,
  output logic                          pad_sel,
  output logic                          busy,
  output logic                          cfg_err,
  output logic [1:0]                    dbg_state
);
  localparam int H = (WIN - 1) / 2;
  localparam logic [RW:0]   H_R  = (RW+1)'(H);
  localparam logic [CW-1:0] H_C  = CW'(H);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] w_q;
  logic [RW-1:0] ht_q;
  logic [CW-1:0] in_col_q;
  logic [RW:0]   in_row_q;
  logic [CW-1:0] c_col_q;
  logic [RW-1:0] c_row_q;
  logic beat, emit, col_last, run_last, flush_last, cfg_bad, accept;
  logic b_row, b_col;

  assign cfg_bad    = (width < CW'(WIN)) || (height < RW'(WIN));
  assign accept     = (state_q == IDLE) && start && !cfg_bad;
  assign col_last   = (in_col_q == w_q - CW'(1));
  assign run_last   = (in_row_q == {1'b0, ht_q} - (RW+1)'(1)) && col_last;
  assign flush_last = (in_row_q == {1'b0, ht_q} + H_R) && (in_col_q == H_C - CW'(1));
  // The cascade holds H rows plus H columns before the first full window exists.
  assign emit       = beat && ((in_row_q > H_R) || ((in_row_q == H_R) && (in_col_q >= H_C)));

  assign b_row = (c_row_q < RW'(H)) || (({1'b0, c_row_q} + H_R + (RW+1)'(1)) > {1'b0, ht_q});
  assign b_col = (c_col_q < H_C) || (({1'b0, c_col_q} + (CW+1)'(H + 1)) > {1'b0, w_q});

  assign fifo_clken  = beat;
  assign fifo_enable = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    beat       = 1'b0;
    s.in_ready = 1'b0;
    pad_sel    = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN: begin
        s.in_ready = s.out_ready;
        beat       = s.in_valid & s.out_ready;
        if (beat && run_last) state_d = FLUSH;
      end
      FLUSH: begin
        pad_sel = 1'b1;
        beat    = s.out_ready;
        if (beat && flush_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cfg_err      <= 1'b0;
      w_q          <= '0;
      ht_q         <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      c_col_q      <= '0;
      c_row_q      <= '0;
      s.out_valid  <= 1'b0;
      s.out_col    <= '0;
      s.out_row    <= '0;
      s.border     <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_err      <= (state_q == IDLE) && start && cfg_bad;
      s.out_valid  <= emit;
      s.frame_done <= emit && (c_row_q == ht_q - RW'(1)) && (c_col_q == w_q - CW'(1));
      if (accept) begin
        w_q      <= width;
        ht_q     <= height;
        in_col_q <= '0;
        in_row_q <= '0;
        c_col_q  <= '0;
        c_row_q  <= '0;
      end else if (beat) begin
        if (col_last) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + (RW+1)'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end
      // Centre counters advance only on beats that actually produce a window.
      if (emit) begin
        s.out_row <= c_row_q;
        s.out_col <= c_col_q;
        s.border  <= b_row | b_col;
        if (c_col_q == w_q - CW'(1)) begin
          c_col_q <= '0;
          c_row_q <= c_row_q + RW'(1);
        end else begin
          c_col_q <= c_col_q + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_linebuf_window_sequencer.sv
// Scoreboard bench for linebuf_window_sequencer: expected centres are queued at frame start
// and popped on every out_valid; beat, pad and handshake counts are checked per frame.
module tb_linebuf_window_sequencer;
  localparam int WIN = 3;
  localparam int CW  = 11;
  localparam int RW  = 11;
  localparam int H   = (WIN - 1) / 2;
  localparam int EW  = 2 + RW + CW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] width;
  logic [RW-1:0] height;
  logic          fifo_clken, fifo_enable, pad_sel, busy, cfg_err;
  logic [1:0]    dbg_state;

  linebuf_window_sequencer_if #(.CW(CW), .RW(RW)) bus ();

  linebuf_window_sequencer #(.WIN(WIN), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height), .s(bus),
    .fifo_clken(fifo_clken), .fifo_enable(fifo_enable), .pad_sel(pad_sel),
    .busy(busy), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [EW-1:0] exp_q[$];

  int beat_cnt, pad_cnt, out_cnt, fd_cnt, ready_viol, en_viol, cyc;
  int first_beat_cyc, last_beat_cyc, exp_first;
  bit first_pending, done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int w, input int h);
    logic [EW-1:0] e;
    logic          b, fd;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        b  = (r < H) || (r > h - 1 - H) || (c < H) || (c > w - 1 - H);
        fd = (r == h - 1) && (c == w - 1);
        e  = {fd, b, RW'(r), CW'(c)};
        exp_q.push_back(e);
      end
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (fifo_enable !== busy) en_viol++;
    if (bus.out_valid) begin
      out_cnt++;
      if (first_pending) begin
        first_pending = 1'b0;
        check("first_out_beat", beat_cnt, exp_first);
      end
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_pixel", {bus.frame_done, bus.border, bus.out_row, bus.out_col}, e);
      end
      if (bus.frame_done) begin
        fd_cnt++;
        done_seen = 1'b1;
      end
    end
    if (fifo_clken) begin
      if (beat_cnt == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beat_cnt++;
      if (pad_sel) pad_cnt++;
      if (!bus.out_ready) ready_viol++;
    end
  end

  // driver tasks
  task automatic do_start(input int w, input int h);
    @(posedge clk); #1;
    width  = CW'(w);
    height = RW'(h);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // rmode: 0 ready always, 1 toggling, 2 random. vmode: 0 valid always, 1 random gaps.
  task automatic run_frame(input int w, input int h, input int rmode, input int vmode,
                           input int abort_beat, input int restart_k);
    int total;
    beat_cnt = 0; pad_cnt = 0; out_cnt = 0; fd_cnt = 0; ready_viol = 0; en_viol = 0;
    done_seen = 1'b0; first_pending = 1'b1; exp_first = H * w + H + 1;
    total = (h + H) * w + H;
    exp_q.delete();
    push_frame(w, h);
    bus.in_valid = 1'b0;
    do_start(w, h);
    for (int k = 0; k < 2000; k++) begin
      bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 2) == 0) : ($urandom_range(0, 2) != 0);
      bus.in_valid  = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (k == restart_k) begin
        width = CW'(5); height = RW'(5); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (abort_beat >= 0 && beat_cnt == abort_beat && fifo_clken) begin
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_fifo_enable", fifo_enable, 0);
        check("abort_fifo_clken", fifo_clken, 0);
        check("abort_outs", {bus.in_ready, pad_sel, bus.border, bus.frame_done, cfg_err, bus.out_row, bus.out_col}, 0);
        check("abort_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (done_seen) break;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("frame_timeout", done_seen, 1);
    check("beat_count", beat_cnt, total);
    check("pad_count", pad_cnt, H * w + H);
    check("out_count", out_cnt, w * h);
    check("frame_done_count", fd_cnt, 1);
    check("beat_without_ready", ready_viol, 0);
    check("enable_vs_busy", en_viol, 0);
    check("queue_drained", exp_q.size(), 0);
    if (rmode == 1) check("toggle_span", last_beat_cyc - first_beat_cyc, 2 * (total - 1));
    @(negedge clk);
    check("idle_after_frame", busy, 0);
  endtask

  task automatic cfg_reject(input int w, input int h);
    @(posedge clk); #1;
    width = CW'(w); height = RW'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_busy", busy, 0);
    check("cfg_fifo_enable", fifo_enable, 0);
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_still_idle", dbg_state, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; width = '0; height = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    exp_first = 0; first_pending = 1'b0; done_seen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_clken_en_pad", {fifo_clken, fifo_enable, pad_sel}, 0);
    check("rst_out", {bus.out_valid, bus.border, bus.frame_done, bus.out_row, bus.out_col}, 0);
    check("rst_busy_cfg", {busy, cfg_err}, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame(4, 3, 0, 0, -1, -1);
    run_frame(4, 3, 1, 0, -1, -1);
    run_frame(4, 3, 0, 1, -1, -1);
    run_frame(6, 5, 2, 1, -1, -1);
    cfg_reject(2, 3);
    cfg_reject(4, 2);
    run_frame(4, 3, 0, 0, 8, -1);
    run_frame(4, 3, 0, 0, -1, -1);
    run_frame(4, 3, 0, 0, -1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
